mem_io_bus: RTL and testbench
=============================

MEM_IO_BUS -- requirements
Module: mem_io_bus

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 16384, meaning data RAM depth in 32-bit words.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, meaning UART bit period in clk cycles (50 MHz / 115200).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning UART TX byte FIFO entries (power of two).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ramAddr  input  32  byte address from the processor.
REQ-007 SHALL have port ramRStrb  input  1  read request, one cycle.
REQ-008 SHALL have port memWData  input  32  write data, already lane-aligned.
REQ-009 SHALL have port memWMask  input  4  byte-lane write enables; nonzero means a write this cycle.
REQ-010 SHALL have port ramRData  output  32  read data.
REQ-011 SHALL have port leds  output  8  LED register.
REQ-012 SHALL have port uartTx  output  1  UART serial line, idle high.

Function
REQ-013 SHALL decode ramAddr[22]=0 as RAM (word index ramAddr[15:2] modulo RAM_WORDS) and ramAddr[22]=1 as IO (register index ramAddr[4:2]).
REQ-014 SHALL register reads: ramRData is valid the cycle after ramRStrb and holds until the next ramRStrb.
REQ-015 SHALL write RAM per byte lane: lane i is written at the edge ending a cycle with memWMask[i]=1; other lanes are unchanged.
REQ-016 SHALL return, for a read in the same cycle as a write to the same word, the old contents (read-before-write).
REQ-017 SHALL implement IO index 0 LED: any nonzero mask writes memWData[7:0] to leds; a read returns {24'b0, leds}.
REQ-018 SHALL implement IO index 1 UART_DATA: any nonzero mask pushes memWData[7:0] into the FIFO; a read returns 0.
REQ-019 SHALL implement IO index 2 UART_STATUS (read-only): bit0 = FIFO full, bit1 = serializer busy, bit2 = FIFO empty, other bits 0.
REQ-020 SHALL return 0 for reads of IO indices 3-7 and ignore writes to them.
REQ-021 SHALL drop a push while the FIFO is full, even if a pop occurs in the same cycle; count is unchanged and no error is flagged.
REQ-022 SHALL accept a push and a pop in the same cycle when not full, leaving the count unchanged.
REQ-023 SHALL maintain FIFO pointers of log2(FIFO_DEPTH)+1 bits that wrap modulo 2*FIFO_DEPTH; full when the MSBs differ and the rest are equal.
REQ-024 SHALL run the serializer FSM through IDLE -> START -> DATA -> STOP -> IDLE.
REQ-025 SHALL, in IDLE with the FIFO non-empty, pop the FIFO and move to START at the next edge.
REQ-026 SHALL hold each of START (line 0), DATA (8 bits, LSB first) and STOP (line 1) for CLKS_PER_BIT cycles per bit.
REQ-027 SHALL, at the end of STOP, return to IDLE; the next byte's start bit follows after exactly one IDLE cycle.
REQ-028 SHALL make serializer busy = (state != IDLE).
REQ-029 SHALL drive uartTx low beginning the second cycle after the write cycle when a byte is written to an empty FIFO with an IDLE serializer.

Reset
REQ-030 SHALL, on reset, set ramRData=0, leds=0, FIFO empty (both pointers 0), FSM=IDLE, bit/baud counters=0 and uartTx=1.
REQ-031 SHALL, on reset asserted mid-frame, abort the frame: uartTx=1 the following cycle and queued bytes are discarded.
REQ-032 SHALL NOT reset RAM contents.

Structure
REQ-033 SHALL place the address map constants (IO select bit 22; LED=0, UART_DATA=1, UART_STATUS=2) and the UART state encoding in a shared package.
REQ-034 SHALL put the FIFO and serializer in one sub-module, uart_tx, with push/data/full/empty/busy/tx ports.

Verification
REQ-035 SHALL cover: write 0xDEADBEEF with mask 1111 to 0x100, then a byte write of 0x55 with mask 0100 -> reading 0x100 returns 0xDE55BEEF one cycle after the strobe.
REQ-036 SHALL cover: write 0xA5 to IO 0x400000 -> leds=0xA5; reading IO 0x400000 returns 0x000000A5.
REQ-037 SHALL cover, with CLKS_PER_BIT=4: write 0x41 to UART_DATA -> uartTx low from write+2 for 4 cycles, then 1,0,0,0,0,0,1,0 for 4 cycles each, then high for 4.
REQ-038 SHALL cover: 6 back-to-back UART_DATA writes while the serializer is busy (FIFO_DEPTH=4) -> status bit0=1; exactly 5 bytes transmitted (1 in flight + 4 queued), in order.
REQ-039 SHALL cover: reset asserted during the DATA state -> uartTx=1 next cycle; status reads 0x4.
REQ-040 SHALL cover: a read and a write to the same RAM word in the same cycle -> ramRData shows the old value and the next read shows the new value.

Source files
------------

// File: rtl/mem_io_bus_pkg.sv
// Shared definitions for the memory/IO bus.
// Holds the address map (IO select bit, IO register indices) and the UART
// serializer state encoding used by mem_io_bus and uart_tx.
package mem_io_bus_pkg;

    // ramAddr bit that steers an access to the IO space instead of RAM.
    localparam int unsigned IoSelBit = 22;

    // IO register indices, taken from ramAddr[4:2].
    localparam logic [2:0] IoLed        = 3'd0;
    localparam logic [2:0] IoUartData   = 3'd1;
    localparam logic [2:0] IoUartStatus = 3'd2;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/mem_io_bus_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   push, data  - enqueue data when push is high (dropped while full)
//   full, empty - FIFO status
//   busy        - serializer is not idle
//   tx          - serial line, idle high
module uart_tx
    import mem_io_bus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW:0]   wr_ptr_q;
    logic [PtrW:0]   rd_ptr_q;
    uart_state_e     state_q;
    logic [CntW-1:0] baud_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            tx_q;

    logic push_ok;
    logic pop;
    logic bit_done;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    // A push while full is dropped even if a pop frees a slot this cycle.
    assign push_ok  = push && !full;
    assign pop      = (state_q == StIdle) && !empty;
    assign bit_done = (baud_cnt_q == CntW'(CLKS_PER_BIT - 1));

    assign busy = (state_q != StIdle);
    assign tx   = tx_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q[PtrW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Serializer. tx is registered so the line changes exactly on state edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    if (pop) begin
                        shift_q <= fifo_mem[rd_ptr_q[PtrW-1:0]];
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        tx_q       <= shift_q[0];
                        state_q    <= StData;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        baud_cnt_q <= '0;
                        tx_q       <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_io_bus.sv
// Processor memory/IO bus: word RAM with byte-lane writes plus a small IO
// space (LED register, UART data and status).
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   ramAddr    - byte address; bit 22 selects IO
//   ramRStrb   - one-cycle read request, data registered into ramRData
//   memWData   - lane-aligned write data
//   memWMask   - byte-lane write enables (nonzero = write)
//   ramRData   - read data, held until the next read
//   leds       - LED register
//   uartTx     - UART serial output
module mem_io_bus
    import mem_io_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = 16384,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ramAddr,
    input  logic        ramRStrb,
    input  logic [31:0] memWData,
    input  logic [3:0]  memWMask,
    output logic [31:0] ramRData,
    output logic [7:0]  leds,
    output logic        uartTx
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [31:0]   mem [RAM_WORDS];
    logic [31:0]   rdata_q;
    logic [7:0]    leds_q;
    logic [31:0]   io_rdata;
    logic [AW-1:0] word_idx;
    logic [2:0]    io_idx;
    logic          is_io;
    logic          wr_en;
    logic          uart_push;
    logic          uart_full;
    logic          uart_empty;
    logic          uart_busy;
    logic          unused_addr;

    assign is_io     = ramAddr[IoSelBit];
    assign io_idx    = ramAddr[4:2];
    assign wr_en     = |memWMask;
    assign word_idx  = AW'(32'(ramAddr[15:2]) % RAM_WORDS);
    assign uart_push = is_io && wr_en && (io_idx == IoUartData);

    assign unused_addr = ^{ramAddr[31:23], ramAddr[21:16], ramAddr[1:0]};

    // RAM is never reset. Nonblocking writes make a same-cycle read see old data.
    always_ff @(posedge clk) begin
        if (!is_io) begin
            for (int i = 0; i < 4; i++) begin
                if (memWMask[i]) begin
                    mem[word_idx][8*i +: 8] <= memWData[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        case (io_idx)
            IoLed:        io_rdata = {24'b0, leds_q};
            IoUartStatus: io_rdata = {29'b0, uart_empty, uart_busy, uart_full};
            default:      io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            leds_q  <= '0;
        end else begin
            if (ramRStrb) begin
                rdata_q <= is_io ? io_rdata : mem[word_idx];
            end
            if (is_io && wr_en && (io_idx == IoLed)) begin
                leds_q <= memWData[7:0];
            end
        end
    end

    assign ramRData = rdata_q;
    assign leds     = leds_q;

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .push  (uart_push),
        .data  (memWData[7:0]),
        .full  (uart_full),
        .empty (uart_empty),
        .busy  (uart_busy),
        .tx    (uartTx)
    );

endmodule

// File: tb/tb_mem_io_bus.sv
// Testbench for mem_io_bus: directed bus transactions, a read scoreboard and
// a UART receiver that checks transmitted bytes against an expected queue.
module tb_mem_io_bus;

    localparam int unsigned RamWords  = 1024;
    localparam int unsigned Cpb       = 4;
    localparam int unsigned FifoDepth = 4;

    localparam logic [31:0] AddrLed    = 32'h0040_0000;
    localparam logic [31:0] AddrUart   = 32'h0040_0004;
    localparam logic [31:0] AddrStatus = 32'h0040_0008;
    localparam logic [31:0] AddrIo5    = 32'h0040_0014;
    localparam logic [31:0] AddrIo7    = 32'h0040_001C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ramAddr;
    logic        ramRStrb;
    logic [31:0] memWData;
    logic [3:0]  memWMask;
    logic [31:0] ramRData;
    logic [7:0]  leds;
    logic        uartTx;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_q[$];
    logic        strb_seen = 1'b0;
    logic        rx_en = 1'b0;

    always #5 clk = ~clk;

    mem_io_bus #(
        .RAM_WORDS    (RamWords),
        .CLKS_PER_BIT (Cpb),
        .FIFO_DEPTH   (FifoDepth)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ramAddr  (ramAddr),
        .ramRStrb (ramRStrb),
        .memWData (memWData),
        .memWMask (memWMask),
        .ramRData (ramRData),
        .leds     (leds),
        .uartTx   (uartTx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each call owns one bus cycle, starting just after a rising edge.
    task automatic drive(input logic [31:0] a, input logic s, input logic [31:0] d,
                         input logic [3:0] m);
        @(posedge clk);
        #1;
        ramAddr  = a;
        ramRStrb = s;
        memWData = d;
        memWMask = m;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        drive(a, 1'b0, d, m);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        drive(a, 1'b1, 32'h0, 4'h0);
    endtask

    task automatic rdwr(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [31:0] exp);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        drive(a, 1'b1, d, m);
    endtask

    // Read scoreboard: data is due the cycle after each strobe.
    always @(posedge clk) strb_seen <= ramRStrb & ~reset;

    initial begin
        forever begin
            @(negedge clk);
            if (strb_seen) begin
                if (rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got %h expected no read", ramRData);
                end else begin
                    check(rd_name_q.pop_front(), ramRData, rd_q.pop_front());
                end
            end
        end
    end

    // UART receiver: samples the second cycle of each bit.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rx_en && !reset && uartTx === 1'b0) begin
                repeat (Cpb + 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = uartTx;
                    if (i < 7) repeat (Cpb) @(negedge clk);
                end
                repeat (Cpb) @(negedge clk);
                check("rx_stop", 32'(uartTx), 32'h1);
                if (tx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_extra: got %h expected no byte", b);
                end else begin
                    check("rx_byte", 32'(b), 32'(tx_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  wbyte;
        logic        e;
        logic        low_seen;
        logic [7:0]  burst [6];

        reset    = 1'b1;
        ramAddr  = '0;
        ramRStrb = 1'b0;
        memWData = '0;
        memWMask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", ramRData, 32'h0);
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_tx", 32'(uartTx), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rx_en = 1'b1;

        // RAM byte lanes, aliasing and same-cycle read/write.
        wr(32'h100, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h100, 32'h0055_0000, 4'b0100);
        rd("ram_lane2", 32'h100, 32'hDE55_BEEF);
        rd("ram_alias", 32'h100 + RamWords * 4, 32'hDE55_BEEF);
        wr(32'h104, 32'h0, 4'b1111);
        wr(32'h104, 32'hAABB_CCDD, 4'b1001);
        rd("ram_lanes30", 32'h104, 32'hAA00_00DD);
        wr(32'h200, 32'h1111_1111, 4'b1111);
        rdwr("ram_rbw_old", 32'h200, 32'h2222_2222, 4'b1111, 32'h1111_1111);
        rd("ram_rbw_new", 32'h200, 32'h2222_2222);

        // LED register and unused IO slots.
        wr(AddrLed, 32'h0000_00A5, 4'b0001);
        idle();
        @(negedge clk);
        check("leds_a5", 32'(leds), 32'hA5);
        rd("led_read", AddrLed, 32'h0000_00A5);
        idle();
        repeat (3) @(negedge clk);
        check("rdata_hold", ramRData, 32'h0000_00A5);
        wr(AddrIo5, 32'hFFFF_FFFF, 4'b1111);
        wr(AddrLed, 32'h1234_563C, 4'b0100);
        rd("io5_read", AddrIo5, 32'h0);
        rd("io7_read", AddrIo7, 32'h0);
        rd("uart_data_read", AddrUart, 32'h0);
        rd("status_idle", AddrStatus, 32'h4);
        rd("led_any_mask", AddrLed, 32'h3C);
        idle();

        // Single byte, cycle-exact waveform.
        wbyte = 8'h41;
        tx_q.push_back(wbyte);
        wr(AddrUart, 32'(wbyte), 4'b0001);
        idle();
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (c == 0) e = 1'b1;
            else if (c < 5) e = 1'b0;
            else if (c < 37) e = wbyte[(c - 5) / 4];
            else e = 1'b1;
            check($sformatf("tx_wave[%0d]", c), 32'(uartTx), 32'(e));
        end

        // Six writes into a depth-4 FIFO: the last is dropped.
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 5; i++) tx_q.push_back(burst[i]);
        for (int i = 0; i < 6; i++) wr(AddrUart, 32'(burst[i]), 4'b0001);
        rd("status_full_busy", AddrStatus, 32'h3);
        idle();
        for (int i = 0; i < 400 && tx_q.size() != 0; i++) @(negedge clk);
        check("tx_drain", 32'(tx_q.size()), 32'h0);
        repeat (10) @(posedge clk);
        rd("status_drained", AddrStatus, 32'h4);
        idle();
        repeat (50) @(negedge clk);

        // Reset in the middle of a frame drops it and the queued byte.
        rx_en = 1'b0;
        wr(AddrUart, 32'h0, 4'b0001);
        wr(AddrUart, 32'h0, 4'b0001);
        idle();
        repeat (7) @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("tx_data_before_reset", 32'(uartTx), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("tx_after_reset", 32'(uartTx), 32'h1);
        check("rdata_after_reset", ramRData, 32'h0);
        check("leds_after_reset", 32'(leds), 32'h0);
        rd("status_after_reset", AddrStatus, 32'h4);
        idle();
        low_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uartTx !== 1'b1) low_seen = 1'b1;
        end
        check("tx_quiet_after_reset", 32'(low_seen), 32'h0);
        rd("ram_kept_over_reset", 32'h100, 32'hDE55_BEEF);
        idle();
        repeat (5) @(negedge clk);

        check("rd_queue_empty", 32'(rd_q.size()), 32'h0);
        check("tx_queue_empty", 32'(tx_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
